// File: rtl/flag_history_reg.sv
// flag_history_reg: condition-flag register with a shifting history of
// older flag snapshots, per-bit masked update of the current flags, and a
// combinational read port that can select any stage.
// Optional build macro FLAG_HIST_STICKY_EN adds a sticky OR of every
// written flag bit; without it sticky_q is tied to zero.
module flag_history_reg #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [WIDTH-1:0]             wmask,
  input  logic [WIDTH-1:0]             flag_in,
  input  logic                         flush,
  input  logic [$clog2(DEPTH+1)-1:0]   rd_stage,
  output logic [WIDTH-1:0]             flags_q,
  output logic [WIDTH-1:0]             rd_flags,
  output logic [DEPTH:0]               hist_valid,
  output logic [WIDTH-1:0]             sticky_q
);

  localparam int SW = $clog2(DEPTH+1);

  // Stage 0 is the live flag set; stages 1..DEPTH are progressively older.
  logic [DEPTH:0][WIDTH-1:0] stage_q;
  logic [DEPTH:0]            vld_q;

  // Stage 0: masked merge of new ALU flags into the current flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q[0] <= RST_VAL;
      vld_q[0]   <= 1'b0;
    end else if (we) begin
      stage_q[0] <= (stage_q[0] & ~wmask) | (flag_in & wmask);
      vld_q[0]   <= 1'b1;
    end
  end

  // History stages: flush clears them outright (and suppresses the shift),
  // otherwise a write pushes the old stage-0 value one step back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= DEPTH; i++) begin
        stage_q[i] <= '0;
        vld_q[i]   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 1; i <= DEPTH; i++) begin
        stage_q[i] <= '0;
        vld_q[i]   <= 1'b0;
      end
    end else if (we) begin
      for (int i = 1; i <= DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
        vld_q[i]   <= vld_q[i-1];
      end
    end
  end

  // Read mux; selections beyond the last stage read as zero rather than X.
  always_comb begin
    rd_flags = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (rd_stage == SW'(i)) rd_flags = stage_q[i];
    end
  end

  assign flags_q    = stage_q[0];
  assign hist_valid = vld_q;

`ifdef FLAG_HIST_STICKY_EN
  logic [WIDTH-1:0] sticky_r;

  // Sticky accumulator: remembers every flag bit ever written as 1; only
  // reset clears it, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_r <= '0;
    end else if (we) begin
      sticky_r <= sticky_r | (flag_in & wmask);
    end
  end

  assign sticky_q = sticky_r;
`else
  assign sticky_q = '0;
`endif

endmodule
